// File: rtl/ctrl_pkg.sv
// Shared control types for the I2S block: operating configuration, TX FSM
// states and slot-geometry helpers.
package ctrl_pkg;

   typedef enum logic {
      f16bits = 1'b0,
      f32bits = 1'b1
   } frame_size_t;

   typedef struct packed {
      logic        stereo;
      frame_size_t frame_size;
   } OP_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      RUN
   } tx_state_t;

   // Index of the last bit in a slot (S-1).
   function automatic logic [4:0] slot_last(frame_size_t fs);
      return (fs == f32bits) ? 5'd31 : 5'd15;
   endfunction

   // Mono mid-slot WS toggle point (S/2-2).
   function automatic logic [4:0] half_toggle(frame_size_t fs);
      return (fs == f32bits) ? 5'd14 : 5'd6;
   endfunction

   // Left-align the S significant bits so the slot MSB sits at bit 31.
   function automatic logic [31:0] slot_align(logic [31:0] w, frame_size_t fs);
      return (fs == f32bits) ? w : {w[15:0], 16'h0000};
   endfunction

endpackage

// File: rtl/sclk_edge_det.sv
// Brings sclk into the pclk domain through a 2-flop synchronizer and a
// history flop, and produces single-cycle fall/rise strobes.
module sclk_edge_det (
   input  logic pclk,
   input  logic rst,
   input  logic sclk,
   output logic fall,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   always_ff @(posedge pclk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= sclk;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign fall = hist_q & ~sync_q;
   assign rise = ~hist_q & sync_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: one-word holding register fed by valid/ready, MSB-first
// serializer and word-select generation, all stepped on detected SCLK falls.
module i2s_tx_serializer
   import ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              pclk,
   input  logic              rst,
   input  OP_t               op,
   input  logic              en,
   input  logic              sclk,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              sd,
   output logic              ws,
   output logic              underrun,
   output logic              frame_start
);

   tx_state_t   state_q, state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic        slot_q, slot_d;
   logic [31:0] shift_q, shift_d;
   logic [31:0] hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic        ready_q, ready_d;
   logic        sd_q, sd_d;
   logic        ws_q, ws_d;
   logic        underrun_q, underrun_d;
   logic        frame_start_q, frame_start_d;

   logic        fall;
   logic        sclk_rise_unused;
   logic        handshake;
   logic        load;
   logic [4:0]  last_idx;
   logic [4:0]  ws_idx;
   logic [4:0]  half_idx;

   sclk_edge_det u_edge (
      .pclk (pclk),
      .rst  (rst),
      .sclk (sclk),
      .fall (fall),
      .rise (sclk_rise_unused)
   );

   assign last_idx    = slot_last(op.frame_size);
   assign ws_idx      = last_idx - 5'd1;
   assign half_idx    = half_toggle(op.frame_size);
   assign tx_ready    = ready_q & en;
   assign handshake   = tx_valid & tx_ready;
   assign sd          = sd_q;
   assign ws          = ws_q;
   assign underrun    = underrun_q;
   assign frame_start = frame_start_q;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      slot_d        = slot_q;
      shift_d       = shift_q;
      hold_d        = hold_q;
      sd_d          = sd_q;
      ws_d          = ws_q;
      underrun_d    = 1'b0;
      frame_start_d = 1'b0;
      load          = 1'b0;

      if (handshake) begin
         hold_d = tx_data[31:0];
      end

      unique case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            slot_d    = 1'b0;
            shift_d   = '0;
            sd_d      = 1'b0;
            ws_d      = 1'b0;
            if (en) begin
               state_d = START;
            end
         end
         START: begin
            if (fall) begin
               sd_d      = 1'b0;
               ws_d      = 1'b0;
               bit_cnt_d = last_idx;
               slot_d    = 1'b0;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (fall) begin
               if (bit_cnt_q == last_idx) begin
                  load          = 1'b1;
                  shift_d       = hold_full_q ? slot_align(hold_q, op.frame_size) : '0;
                  underrun_d    = ~hold_full_q;
                  frame_start_d = ~slot_q;
                  slot_d        = op.stereo & ~slot_q;
                  bit_cnt_d     = '0;
                  sd_d          = shift_d[31];
               end else begin
                  shift_d   = shift_q << 1;
                  sd_d      = shift_q[30];
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
               // WS flips one bit ahead of the slot (or half-slot) boundary.
               if ((bit_cnt_q == ws_idx) || (!op.stereo && (bit_cnt_q == half_idx))) begin
                  ws_d = ~ws_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A load drains the old word before a same-cycle handshake refills it.
      hold_full_d = handshake ? 1'b1 : (load ? 1'b0 : hold_full_q);

      if (!en) begin
         state_d       = IDLE;
         bit_cnt_d     = '0;
         slot_d        = 1'b0;
         shift_d       = '0;
         sd_d          = 1'b0;
         ws_d          = 1'b0;
         hold_full_d   = 1'b0;
         underrun_d    = 1'b0;
         frame_start_d = 1'b0;
      end

      ready_d = en & ~hold_full_d;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         slot_q        <= 1'b0;
         shift_q       <= '0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         ready_q       <= 1'b0;
         sd_q          <= 1'b0;
         ws_q          <= 1'b0;
         underrun_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         slot_q        <= slot_d;
         shift_q       <= shift_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         ready_q       <= ready_d;
         sd_q          <= sd_d;
         ws_q          <= ws_d;
         underrun_q    <= underrun_d;
         frame_start_q <= frame_start_d;
      end
   end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: SCLK = PCLK/6, fall-indexed reference model of
// the I2S stream plus directed pattern captures for the fixed test words.
module tb_i2s_tx_serializer;
   import ctrl_pkg::*;

   localparam int unsigned DATA_W = 32;

   logic              pclk = 1'b0;
   logic              rst, en, sclk, tx_valid;
   logic              tx_ready, sd, ws, underrun, frame_start;
   logic [DATA_W-1:0] tx_data;
   OP_t               op, op_cmd;

   i2s_tx_serializer #(.DATA_W(DATA_W)) dut (
      .pclk        (pclk),
      .rst         (rst),
      .op          (op),
      .en          (en),
      .sclk        (sclk),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .sd          (sd),
      .ws          (ws),
      .underrun    (underrun),
      .frame_start (frame_start)
   );

   always #5 pclk = ~pclk;

   int errors = 0;
   int checks = 0;

   logic        rst_cmd, en_cmd;
   int          phase;
   logic [31:0] feed[$];
   logic        feed_on, feed_rand;

   typedef enum {M_IDLE, M_START, M_RUN} mmode_t;
   mmode_t      m_mode;
   int          m_pos;
   logic        m_full, m_ready;
   logic [31:0] m_hold, m_word;
   logic        exp_sd, exp_ws, exp_ur, exp_fs;
   int          n_ur, n_fs;

   logic         cap_on;
   int           cap_n;
   logic [127:0] cap_sd, cap_ws;

   task automatic check_bit(input string tag, input logic got, input logic want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s t=%0t got=%b want=%b", tag, $time, got, want);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic check_vec(input string tag, input int n, input logic [127:0] got,
                            input logic [127:0] want);
      logic [127:0] mask;
      mask = (128'd1 << n) - 128'd1;
      checks++;
      assert ((got & mask) === want) else begin
         errors++;
         $error("FAIL %s got=%0h want=%0h", tag, got & mask, want);
      end
   endtask

   // Expected line state as a function of the fall index since START.
   task automatic model_edge(input logic hs);
      int S;
      S = (op.frame_size == f32bits) ? 32 : 16;
      exp_ur = 1'b0;
      exp_fs = 1'b0;
      if (rst || !en) begin
         m_mode  = M_IDLE;
         m_full  = 1'b0;
         m_ready = 1'b0;
         exp_sd  = 1'b0;
         exp_ws  = 1'b0;
         m_pos   = -1;
      end else begin
         if (m_mode == M_IDLE) begin
            m_mode = M_START;
         end else if (phase == 2) begin
            if (m_mode == M_START) begin
               m_mode = M_RUN;
               m_pos  = -1;
               exp_sd = 1'b0;
               exp_ws = 1'b0;
            end else begin
               int b;
               m_pos++;
               b = m_pos % S;
               if (b == 0) begin
                  if (m_full) begin
                     m_word = m_hold;
                     m_full = 1'b0;
                  end else begin
                     m_word = '0;
                     exp_ur = 1'b1;
                  end
                  exp_fs = op.stereo ? (((m_pos / S) % 2) == 0) : 1'b1;
               end
               exp_sd = m_word[S-1-b];
               if (op.stereo) exp_ws = (((m_pos + 1) / S) % 2) == 1;
               else           exp_ws = (b >= S/2 - 1) && (b <= S - 2);
            end
         end
         if (hs) begin
            m_hold = tx_data;
            m_full = 1'b1;
         end
         m_ready = ~m_full;
      end
   endtask

   task automatic tick();
      logic hs;
      @(negedge pclk);
      check_bit("sd", sd, exp_sd);
      check_bit("ws", ws, exp_ws);
      check_bit("underrun", underrun, exp_ur);
      check_bit("frame_start", frame_start, exp_fs);
      check_bit("tx_ready", tx_ready, m_ready & en);
      if (cap_on && phase == 2 && m_mode == M_RUN) begin
         cap_sd = {cap_sd[126:0], sd};
         cap_ws = {cap_ws[126:0], ws};
         cap_n++;
      end
      phase = (phase + 1) % 6;
      sclk  = (phase < 3) ? 1'b0 : 1'b1;
      rst   = rst_cmd;
      en    = en_cmd;
      op    = op_cmd;
      if (feed_on && feed.size() > 0 && (!feed_rand || $urandom_range(1, 0) == 1)) begin
         tx_valid = 1'b1;
         tx_data  = feed[0];
      end else begin
         tx_valid = 1'b0;
         tx_data  = $urandom;
      end
      #1;
      hs = tx_valid & tx_ready & ~rst;
      if (hs) void'(feed.pop_front());
      @(posedge pclk);
      model_edge(hs);
      if (exp_ur) n_ur++;
      if (exp_fs) n_fs++;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_pos(input int p);
      int guard;
      guard = 0;
      while (!(m_mode == M_RUN && m_pos == p) && guard < 3000) begin
         tick();
         guard++;
      end
      checks++;
      assert (guard < 3000) else begin
         errors++;
         $error("FAIL wait_pos_%0d timeout got=%0d want=%0d", p, m_pos, p);
      end
   endtask

   // Reset edge lands on an SCLK-high phase so fall timing stays regular.
   task automatic pulse_reset();
      while (phase != 2) tick();
      rst_cmd = 1'b1;
      tick();
      rst_cmd = 1'b0;
   endtask

   task automatic disable_tx();
      en_cmd = 1'b0;
      run_ticks(3);
   endtask

   task automatic push_random(input int n);
      for (int i = 0; i < n; i++) feed.push_back($urandom);
   endtask

   task automatic start_capture();
      cap_on = 1'b1;
      cap_n  = 0;
      cap_sd = '0;
      cap_ws = '0;
      n_fs   = 0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; sclk = 1'b1; tx_valid = 1'b0; tx_data = '0;
      rst_cmd = 1'b1; en_cmd = 1'b0; phase = 5;
      op_cmd = '{stereo: 1'b1, frame_size: f16bits};
      op = op_cmd;
      feed_on = 1'b0; feed_rand = 1'b0; cap_on = 1'b0; cap_n = 0;
      cap_sd = '0; cap_ws = '0;
      m_mode = M_IDLE; m_pos = -1; m_full = 1'b0; m_ready = 1'b0;
      m_hold = '0; m_word = '0;
      exp_sd = 1'b0; exp_ws = 1'b0; exp_ur = 1'b0; exp_fs = 1'b0;
      n_ur = 0; n_fs = 0;
      repeat (2) @(posedge pclk);
      pulse_reset();
      run_ticks(4);

      // Stereo f16, L=A5A5 R=3C3C preloaded
      feed.push_back(32'h0000_A5A5);
      feed.push_back(32'h0000_3C3C);
      push_random(8);
      feed_on = 1'b1;
      start_capture();
      en_cmd = 1'b1;
      wait_pos(31);
      tick();
      cap_on = 1'b0;
      check_int("s1_cap_count", cap_n, 33);
      check_vec("s1_sd_pattern", 33, cap_sd, 128'h0_A5A5_3C3C);
      check_vec("s1_ws_pattern", 33, cap_ws, 128'h1_FFFE);
      check_int("s1_frame_start", n_fs, 1);
      run_ticks(400);

      // Stereo f32
      disable_tx();
      op_cmd = '{stereo: 1'b1, frame_size: f32bits};
      feed.delete();
      feed.push_back(32'h8000_0001);
      feed.push_back(32'h7FFF_FFFE);
      push_random(6);
      run_ticks(2);
      start_capture();
      en_cmd = 1'b1;
      wait_pos(63);
      tick();
      cap_on = 1'b0;
      check_int("s2_cap_count", cap_n, 65);
      check_vec("s2_sd_pattern", 65, cap_sd, 128'h0_8000_0001_7FFF_FFFE);
      check_vec("s2_ws_pattern", 65, cap_ws, 128'h1_FFFF_FFFE);
      run_ticks(600);

      // Mono f16, random valid gaps afterwards
      disable_tx();
      op_cmd = '{stereo: 1'b0, frame_size: f16bits};
      feed.delete();
      feed.push_back(32'h0000_F00F);
      push_random(8);
      run_ticks(2);
      start_capture();
      en_cmd = 1'b1;
      wait_pos(15);
      tick();
      cap_on = 1'b0;
      check_int("s3_cap_count", cap_n, 17);
      check_vec("s3_sd_pattern", 17, cap_sd, 128'h0_F00F);
      check_vec("s3_ws_pattern", 17, cap_ws, 128'h1FE);
      check_int("s3_frame_start", n_fs, 1);
      feed_rand = 1'b1;
      run_ticks(500);
      feed_rand = 1'b0;

      // Underrun: one word only, resume mid R slot, then a starve where
      // the refill handshake lands on the load edge
      disable_tx();
      op_cmd = '{stereo: 1'b1, frame_size: f16bits};
      feed.delete();
      push_random(1);
      run_ticks(2);
      n_ur = 0;
      en_cmd = 1'b1;
      wait_pos(20);
      check_int("s4_underrun_r", n_ur, 1);
      push_random(3);
      wait_pos(47);
      check_int("s4_after_resume", n_ur, 1);
      feed.delete();
      wait_pos(63);
      run_ticks(5);
      push_random(1);
      wait_pos(80);
      check_int("s4_same_cycle", n_ur, 2);
      push_random(6);
      run_ticks(400);

      // en dropped at bit 5 of the R slot, then re-enable
      disable_tx();
      feed.delete();
      push_random(6);
      en_cmd = 1'b1;
      wait_pos(21);
      en_cmd = 1'b0;
      run_ticks(5);
      feed.delete();
      feed.push_back(32'h0000_A5A5);
      feed.push_back(32'h0000_3C3C);
      push_random(4);
      start_capture();
      en_cmd = 1'b1;
      wait_pos(31);
      tick();
      cap_on = 1'b0;
      check_int("s5_cap_count", cap_n, 33);
      check_vec("s5_sd_pattern", 33, cap_sd, 128'h0_A5A5_3C3C);
      check_vec("s5_ws_pattern", 33, cap_ws, 128'h1_FFFE);

      // Reset mid-RUN, restart with the scenario-1 words
      wait_pos(40);
      feed_on = 1'b0;
      pulse_reset();
      feed.delete();
      feed.push_back(32'h0000_A5A5);
      feed.push_back(32'h0000_3C3C);
      push_random(4);
      feed_on = 1'b1;
      start_capture();
      wait_pos(31);
      tick();
      cap_on = 1'b0;
      check_int("s6_cap_count", cap_n, 33);
      check_vec("s6_sd_pattern", 33, cap_sd, 128'h0_A5A5_3C3C);
      check_vec("s6_ws_pattern", 33, cap_ws, 128'h1_FFFE);
      check_int("s6_frame_start", n_fs, 1);
      run_ticks(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
